// File: rtl/glitchless_output_mux_if.sv
// Request/bus bundle for the glitchless output mux.
// The master drives the source lines and the select requests.
// The slave (the mux) returns the registered output and the status.
interface glitchless_output_mux_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] in_line0;
   logic [WIDTH-1:0] in_line1;
   logic [WIDTH-1:0] sel_req;
   logic             sel_req_valid;
   logic             sel_req_ready;
   logic             force_apply;
   logic [WIDTH-1:0] out_line;
   logic [WIDTH-1:0] select_active;
   logic             switch_done;
   logic             timed_out;

   modport master (
      output in_line0,
      output in_line1,
      output sel_req,
      output sel_req_valid,
      output force_apply,
      input  sel_req_ready,
      input  out_line,
      input  select_active,
      input  switch_done,
      input  timed_out
   );

   modport slave (
      input  in_line0,
      input  in_line1,
      input  sel_req,
      input  sel_req_valid,
      input  force_apply,
      output sel_req_ready,
      output out_line,
      output select_active,
      output switch_done,
      output timed_out
   );
endinterface

// File: rtl/glitchless_output_mux.sv
// Registered per-bit 2:1 output mux between the pass-through line (in_line0)
// and the injected line (in_line1). A requested select bit only changes in a
// cycle where both sources agree on that bit, so the switch itself never puts
// an edge on the target bus. A timeout or force_apply flushes whatever bits
// are still waiting.
module glitchless_output_mux #(
   parameter int WIDTH          = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   glitchless_output_mux_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // Counter value at which the last waiting cycle is reached; only used
   // when the timeout is enabled.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic                 TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     act_q, act_d;
   logic [WIDTH-1:0]     pend_q, pend_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 tflag_q, tflag_d;
   logic [WIDTH-1:0]     out_q, out_d;

   logic [WIDTH-1:0]     diff;
   logic [WIDTH-1:0]     safe;
   logic [WIDTH-1:0]     flip;
   logic                 tmo_hit;

   // Next-state, select update and registered mux output for this edge.
   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      tflag_d = tflag_q;
      diff    = bus.in_line0 ^ bus.in_line1;
      safe    = pend_q & ~diff;
      tmo_hit = TMO_EN && (cnt_q == CNT_LAST);
      flip    = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.sel_req_valid) begin
               pend_d  = bus.sel_req ^ act_q;
               cnt_d   = '0;
               tflag_d = 1'b0;
               state_d = ST_PENDING;
            end
         end

         ST_PENDING: begin
            // Forcing flips every remaining bit regardless of line agreement.
            flip   = (bus.force_apply || tmo_hit) ? pend_q : safe;
            act_d  = act_q ^ flip;
            pend_d = pend_q & ~flip;
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (pend_d == '0) begin
               state_d = ST_DONE;
               // Only bits that the timeout pushed through unsafely count;
               // an explicit force in the same cycle takes precedence.
               tflag_d = tmo_hit && !bus.force_apply && ((pend_q & ~safe) != '0);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            tflag_d = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      out_d = (~act_d & bus.in_line0) | (act_d & bus.in_line1);
   end

   // State, select mask, pending mask, wait counter and output register.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         act_q   <= '0;
         pend_q  <= '0;
         cnt_q   <= '0;
         tflag_q <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         tflag_q <= tflag_d;
         out_q   <= out_d;
      end
   end

   assign bus.sel_req_ready = (state_q == ST_IDLE);
   assign bus.switch_done   = (state_q == ST_DONE);
   assign bus.timed_out     = (state_q == ST_DONE) && tflag_q;
   assign bus.out_line      = out_q;
   assign bus.select_active = act_q;

endmodule

// File: tb/tb_glitchless_output_mux.sv
// Bench for glitchless_output_mux: directed requests, with completion
// expectations queued at issue time and checked by an independent monitor.
module tb_glitchless_output_mux;
   localparam int WIDTH = 4;
   localparam int TMO   = 8;

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;

   glitchless_output_mux_if #(.WIDTH(WIDTH)) bus ();

   glitchless_output_mux #(
      .WIDTH(WIDTH),
      .TIMEOUT_CYCLES(TMO),
      .CNT_WIDTH(16)
   ) dut (
      .sys_clk(sys_clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [WIDTH-1:0] act;
      logic             to;
      int               cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic request(input logic [WIDTH-1:0] m);
      bus.sel_req       = m;
      bus.sel_req_valid = 1'b1;
      tick();
      bus.sel_req_valid = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] a, input logic t, input int c);
      exp_t e;
      e.act = a;
      e.to  = t;
      e.cyc = c;
      exp_q.push_back(e);
   endtask

   // Completion monitor
   always @(negedge sys_clk) begin
      exp_t e;
      if (bus.switch_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got switch_done=1 expected no completion");
         end else begin
            e = exp_q.pop_front();
            check("done_select", 32'(bus.select_active), 32'(e.act));
            check("done_timed_out", 32'(bus.timed_out), 32'(e.to));
            if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
         end
      end else if (bus.timed_out !== 1'b0) begin
         check("timed_out_alone", 32'(bus.timed_out), 32'd0);
      end
   end

   initial begin
      bus.in_line0      = 4'h0;
      bus.in_line1      = 4'hF;
      bus.sel_req       = 4'hF;
      bus.sel_req_valid = 1'b1;
      bus.force_apply   = 1'b0;

      // Reset with a live request and active injected line
      rst = 1'b1;
      tick();
      tick();
      check("reset_out_line", 32'(bus.out_line), 32'h0);
      check("reset_select", 32'(bus.select_active), 32'h0);
      check("reset_ready", 32'(bus.sel_req_ready), 32'h1);
      check("reset_done", 32'(bus.switch_done), 32'h0);
      rst               = 1'b0;
      bus.sel_req_valid = 1'b0;
      bus.in_line1      = 4'h0;
      tick();

      // Request equal to the current mask: one PENDING cycle, zero flips
      request(4'h0);
      push(4'h0, 1'b0, cyc + 1);
      check("eq_ready_busy", 32'(bus.sel_req_ready), 32'h0);
      tick();
      tick();
      check("eq_ready_back", 32'(bus.sel_req_ready), 32'h1);

      // Immediate safe switch: both sources agree everywhere
      bus.in_line0 = 4'b1010;
      bus.in_line1 = 4'b1010;
      request(4'hF);
      push(4'hF, 1'b0, cyc + 1);
      check("imm_out_pre", 32'(bus.out_line), 32'hA);
      tick();
      check("imm_select", 32'(bus.select_active), 32'hF);
      check("imm_out", 32'(bus.out_line), 32'hA);
      tick();
      check("imm_ready", 32'(bus.sel_req_ready), 32'h1);

      // Return to pass-through
      bus.in_line0 = 4'h0;
      bus.in_line1 = 4'h0;
      request(4'h0);
      push(4'h0, 1'b0, cyc + 1);
      tick();
      tick();

      // Partial wait: bits switch one by one as the lines come into agreement
      bus.in_line1 = 4'b0011;
      request(4'b0011);
      push(4'b0011, 1'b0, -1);
      tick();
      tick();
      check("partial_hold", 32'(bus.select_active), 32'h0);
      check("partial_out", 32'(bus.out_line), 32'h0);
      bus.in_line1 = 4'b0010;
      tick();
      check("partial_bit0", 32'(bus.select_active), 32'h1);
      check("partial_no_done", 32'(bus.switch_done), 32'h0);
      bus.in_line1 = 4'b0000;
      tick();
      check("partial_bit1", 32'(bus.select_active), 32'h3);
      tick();

      // Back to pass-through (all bits safe)
      request(4'h0);
      push(4'h0, 1'b0, cyc + 1);
      tick();
      tick();

      // Timeout: sources never agree
      bus.in_line1 = 4'hF;
      request(4'hF);
      push(4'hF, 1'b1, cyc + TMO);
      repeat (TMO - 1) tick();
      check("tmo_hold", 32'(bus.select_active), 32'h0);
      tick();
      check("tmo_select", 32'(bus.select_active), 32'hF);
      check("tmo_out", 32'(bus.out_line), 32'hF);
      tick();

      // force_apply in IDLE does nothing
      bus.force_apply = 1'b1;
      tick();
      bus.force_apply = 1'b0;
      check("idle_force_select", 32'(bus.select_active), 32'hF);
      check("idle_force_ready", 32'(bus.sel_req_ready), 32'h1);

      // Busy request ignored, then force completes without timed_out
      request(4'h0);
      push(4'h0, 1'b0, -1);
      tick();
      bus.sel_req       = 4'b0101;
      bus.sel_req_valid = 1'b1;
      check("busy_ready", 32'(bus.sel_req_ready), 32'h0);
      tick();
      check("busy_hold", 32'(bus.select_active), 32'hF);
      bus.force_apply = 1'b1;
      tick();
      bus.force_apply = 1'b0;
      check("force_select", 32'(bus.select_active), 32'h0);
      check("force_out", 32'(bus.out_line), 32'h0);
      check("done_ready", 32'(bus.sel_req_ready), 32'h0);
      tick();
      check("ready_again", 32'(bus.sel_req_ready), 32'h1);
      tick();
      push(4'b0101, 1'b1, cyc + TMO);
      bus.sel_req_valid = 1'b0;
      check("accept_busy", 32'(bus.sel_req_ready), 32'h0);
      repeat (TMO) tick();
      check("new_mask", 32'(bus.select_active), 32'h5);
      tick();

      // Reset mid-operation with two bits pending
      request(4'hF);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_select", 32'(bus.select_active), 32'h0);
      check("rst_ready", 32'(bus.sel_req_ready), 32'h1);
      check("rst_out", 32'(bus.out_line), 32'h0);
      check("rst_done", 32'(bus.switch_done), 32'h0);
      repeat (3) tick();
      check("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
